serial_frame_rx: RTL and testbench

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

---
 rtl/serial_frame_rx_if.sv | 31 +++
 rtl/serial_frame_rx.sv | 162 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Bundle of the serial bit input and the decoded byte/status outputs of the
// serial frame receiver. The master side feeds bits, the slave side decodes.
interface serial_frame_rx_if;
    logic       bit_in;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       sync_lock;
    logic       frame_err;
    logic       frame_done;

    modport master (
        output bit_in,
        output bit_valid,
        input  byte_out,
        input  byte_valid,
        input  sync_lock,
        input  frame_err,
        input  frame_done
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output byte_out,
        output byte_valid,
        output sync_lock,
        output frame_err,
        output frame_done
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for a sync byte in the bit stream, then
// collects FRAME_LEN data bytes, each followed by an even-parity bit.
// All outputs come straight from flops.
module serial_frame_rx #(
    parameter logic [7:0] SYNC      = 8'hA5,
    parameter int         FRAME_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    serial_frame_rx_if.slave   bus
);

    localparam logic [8:0] FRAME_LEN_C = FRAME_LEN[8:0];

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    // Even parity: ones in data plus parity bit must be even.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ~((^data) ^ par);
    endfunction

    state_e     state_q,      state_d;
    logic [7:0] hunt_sr_q,    hunt_sr_d;
    logic [3:0] hunt_cnt_q,   hunt_cnt_d;
    logic [7:0] data_sr_q,    data_sr_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [7:0] byte_cnt_q,   byte_cnt_d;
    logic [7:0] byte_out_q,   byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       sync_lock_q,  sync_lock_d;
    logic       frame_err_q,  frame_err_d;
    logic       frame_done_q, frame_done_d;

    logic [7:0] hunt_shift_s;
    logic [3:0] hunt_cnt_inc_s;
    logic       last_byte_s;

    // Next-state and next-output computation for the receive FSM.
    always_comb begin
        state_d        = state_q;
        hunt_sr_d      = hunt_sr_q;
        hunt_cnt_d     = hunt_cnt_q;
        data_sr_d      = data_sr_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        byte_out_d     = byte_out_q;
        byte_valid_d   = 1'b0;
        frame_err_d    = 1'b0;
        frame_done_d   = 1'b0;

        hunt_shift_s   = {hunt_sr_q[6:0], bus.bit_in};
        hunt_cnt_inc_s = (hunt_cnt_q == 4'd8) ? 4'd8 : (hunt_cnt_q + 4'd1);
        last_byte_s    = (({1'b0, byte_cnt_q} + 9'd1) == FRAME_LEN_C);

        case (state_q)
            ST_HUNT: begin
                if (bus.bit_valid) begin
                    if ((hunt_shift_s == SYNC) && (hunt_cnt_inc_s >= 4'd8)) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 8'd0;
                        hunt_sr_d  = 8'h00;
                        hunt_cnt_d = 4'd0;
                    end else begin
                        hunt_sr_d  = hunt_shift_s;
                        hunt_cnt_d = hunt_cnt_inc_s;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (bus.bit_valid) begin
                    data_sr_d = {data_sr_q[6:0], bus.bit_in};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_PARITY: begin
                if (bus.bit_valid) begin
                    if (parity_ok(data_sr_q, bus.bit_in)) begin
                        byte_out_d   = data_sr_q;
                        byte_valid_d = 1'b1;
                        if (last_byte_s) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_HUNT;
                            hunt_sr_d    = 8'h00;
                            hunt_cnt_d   = 4'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                            bit_cnt_d  = 3'd0;
                            state_d    = ST_DATA;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_HUNT;
                        hunt_sr_d   = 8'h00;
                        hunt_cnt_d  = 4'd0;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                // Unused encoding: recover on this edge regardless of bit_valid.
                state_d    = ST_HUNT;
                hunt_sr_d  = 8'h00;
                hunt_cnt_d = 4'd0;
                bit_cnt_d  = 3'd0;
                byte_cnt_d = 8'd0;
            end
        endcase

        sync_lock_d = (state_d == ST_DATA) || (state_d == ST_PARITY);
    end

    // State and output registers, cleared immediately by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            hunt_sr_q    <= 8'h00;
            hunt_cnt_q   <= 4'd0;
            data_sr_q    <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 8'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            sync_lock_q  <= 1'b0;
            frame_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hunt_sr_q    <= hunt_sr_d;
            hunt_cnt_q   <= hunt_cnt_d;
            data_sr_q    <= data_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            sync_lock_q  <= sync_lock_d;
            frame_err_q  <= frame_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.sync_lock  = sync_lock_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx with hand-computed expectations.
module tb_serial_frame_rx;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n_valid;
    int   n_err;
    int   n_done;
    int   n_done_with_valid;
    logic gap_en;

    serial_frame_rx_if bus ();

    serial_frame_rx #(.SYNC(8'hA5), .FRAME_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor: counts every cycle a pulse output is seen high.
    initial begin
        n_valid = 0;
        n_err = 0;
        n_done = 0;
        n_done_with_valid = 0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.byte_valid) n_valid++;
            if (bus.frame_err) n_err++;
            if (bus.frame_done) n_done++;
            if (bus.frame_done && bus.byte_valid) n_done_with_valid++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.bit_in = b;
        bus.bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'($urandom_range(0, 1));
        if (gap_en) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_data(input logic [7:0] b, input logic p);
        send_byte(b);
        send_bit(p);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.bit_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic good_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input string tag);
        int v0, d0, w0, e0;
        v0 = n_valid; d0 = n_done; w0 = n_done_with_valid; e0 = n_err;
        send_byte(8'hA5);
        send_data(b0, ^b0);
        send_data(b1, ^b1);
        send_data(b2, ^b2);
        send_data(b3, ^b3);
        @(posedge clk);
        #1;
        check_eq({tag, "_valid_cnt"}, 32'(n_valid - v0), 32'd4);
        check_eq({tag, "_done_cnt"}, 32'(n_done - d0), 32'd1);
        check_eq({tag, "_done_with_valid"}, 32'(n_done_with_valid - w0), 32'd1);
        check_eq({tag, "_err_cnt"}, 32'(n_err - e0), 32'd0);
        check_eq({tag, "_last_byte"}, 32'(bus.byte_out), 32'(b3));
        check_eq({tag, "_lock_after"}, 32'(bus.sync_lock), 32'd0);
    endtask

    initial begin
        int v0, e0, d0;
        logic early;
        logic [11:0] ovl;
        total = 0;
        bad = 0;
        gap_en = 1'b0;
        rst = 1'b0;
        bus.bit_in = 1'b0;
        bus.bit_valid = 1'b0;

        // Reset state
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_byte_out", 32'(bus.byte_out), 32'h00);
        check_eq("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
        check_eq("rst_sync_lock", 32'(bus.sync_lock), 32'd0);
        check_eq("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic lock and first byte 0x3C, parity 0
        v0 = n_valid;
        for (int i = 7; i >= 1; i--) send_bit(8'hA5 >> i);
        check_eq("lock_before_8th", 32'(bus.sync_lock), 32'd0);
        send_bit(1'b1);
        check_eq("lock_after_8th", 32'(bus.sync_lock), 32'd1);
        send_data(8'h3C, 1'b0);
        check_eq("b3c_valid_now", 32'(bus.byte_valid), 32'd1);
        check_eq("b3c_byte_out", 32'(bus.byte_out), 32'h3C);
        @(posedge clk);
        #1;
        check_eq("b3c_valid_gone", 32'(bus.byte_valid), 32'd0);
        check_eq("b3c_valid_cnt", 32'(n_valid - v0), 32'd1);
        check_eq("b3c_still_locked", 32'(bus.sync_lock), 32'd1);

        // Full 4-byte frame, detailed check at the final byte
        do_reset();
        v0 = n_valid;
        send_byte(8'hA5);
        send_data(8'h01, 1'b1);
        send_data(8'h02, 1'b1);
        send_data(8'h03, 1'b0);
        send_data(8'hFF, 1'b0);
        check_eq("f4_done_now", 32'(bus.frame_done), 32'd1);
        check_eq("f4_valid_now", 32'(bus.byte_valid), 32'd1);
        check_eq("f4_byte_ff", 32'(bus.byte_out), 32'hFF);
        check_eq("f4_lock_low", 32'(bus.sync_lock), 32'd0);
        @(posedge clk);
        #1;
        check_eq("f4_done_gone", 32'(bus.frame_done), 32'd0);
        check_eq("f4_valid_cnt", 32'(n_valid - v0), 32'd4);

        // Bits after frame end are hunt bits; then parity error frame
        v0 = n_valid; e0 = n_err;
        send_byte(8'hA5);
        check_eq("relock_after_frame", 32'(bus.sync_lock), 32'd1);
        send_data(8'h3C, 1'b1);
        check_eq("perr_err_now", 32'(bus.frame_err), 32'd1);
        check_eq("perr_lock_low", 32'(bus.sync_lock), 32'd0);
        check_eq("perr_byte_kept", 32'(bus.byte_out), 32'hFF);
        @(posedge clk);
        #1;
        check_eq("perr_err_cnt", 32'(n_err - e0), 32'd1);
        check_eq("perr_no_valid", 32'(n_valid - v0), 32'd0);

        // Overlapping sync: 1010 1010 0101 locks only on the 12th bit
        do_reset();
        ovl = 12'b1010_1010_0101;
        early = 1'b0;
        for (int i = 11; i >= 1; i--) begin
            send_bit(ovl[i]);
            if (bus.sync_lock) early = 1'b1;
        end
        check_eq("ovl_no_early_lock", 32'(early), 32'd0);
        send_bit(ovl[0]);
        check_eq("ovl_lock_12th", 32'(bus.sync_lock), 32'd1);

        // bit_valid toggling: same results, stretched in time
        do_reset();
        gap_en = 1'b1;
        good_frame(8'h01, 8'h02, 8'h03, 8'hFF, "gap");
        gap_en = 1'b0;

        // Reset mid-frame, then a fresh frame decodes
        do_reset();
        send_byte(8'hA5);
        for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
        v0 = n_valid; e0 = n_err; d0 = n_done;
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_lock", 32'(bus.sync_lock), 32'd0);
        check_eq("mid_rst_byte_out", 32'(bus.byte_out), 32'h00);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_no_pulses", 32'((n_valid - v0) + (n_err - e0) + (n_done - d0)), 32'd0);
        good_frame(8'h81, 8'h7E, 8'h3C, 8'h55, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
